// File: rtl/tap_pkg.sv
// -----------------------------------------------------------------------------
// tap_pkg
// Shared types and constants for the JTAG TAP controller.
//   tap_state_t   : 16-state IEEE 1149.1 TAP state, IEEE encoding (TLR = 4'hF)
//   INST_*        : 2-bit instruction codes seen on the live `inst` input
//   tap_strobes_t : bundle of decoded strobes, one field per controller output
//   inst_is_boundary() : true when the instruction routes DR to the boundary chain
// -----------------------------------------------------------------------------
package tap_pkg;

  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PAU_DR = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PAU_IR = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_t;

  localparam logic [1:0] INST_EXTEST = 2'b00;
  localparam logic [1:0] INST_SAMPLE = 2'b01;
  localparam logic [1:0] INST_IDCODE = 2'b10;
  localparam logic [1:0] INST_BYPASS = 2'b11;

  typedef struct packed {
    logic shiftir;
    logic updateir;
    logic shiftdr;
    logic clockdr;
    logic updatedr;
    logic bs_en;
    logic ir_rst;
    logic tdo_en;
  } tap_strobes_t;

  function automatic logic inst_is_boundary(input logic [1:0] inst);
    return (inst == INST_EXTEST) || (inst == INST_SAMPLE);
  endfunction

endpackage : tap_pkg

// File: rtl/tap_controller_if.sv
// -----------------------------------------------------------------------------
// tap_controller_if
// Groups every TAP signal except the clock (TCK) and reset (TRST).
//   Inputs to the controller : TMS, TDI, inst[1:0], ir_tdo, bs_tdo
//   Outputs from controller  : shiftir, updateir, shiftdr, clockdr, updatedr,
//                              bs_en, ir_rst, TDO, tdo_en, state
// Modports:
//   master : the side that drives TMS/TDI/inst and the chain outputs
//   slave  : the TAP controller itself
// Handshake semantics: there is no valid/ready pair; every input is sampled on
// each rising TCK and every output is a level that is valid for the whole
// cycle following the edge that produced it.
// -----------------------------------------------------------------------------
import tap_pkg::*;

interface tap_controller_if;
  logic       TMS;
  logic       TDI;
  logic [1:0] inst;
  logic       ir_tdo;
  logic       bs_tdo;

  logic       shiftir;
  logic       updateir;
  logic       shiftdr;
  logic       clockdr;
  logic       updatedr;
  logic       bs_en;
  logic       ir_rst;
  logic       TDO;
  logic       tdo_en;
  tap_state_t state;

  modport master (
    output TMS, TDI, inst, ir_tdo, bs_tdo,
    input  shiftir, updateir, shiftdr, clockdr, updatedr,
           bs_en, ir_rst, TDO, tdo_en, state
  );

  modport slave (
    input  TMS, TDI, inst, ir_tdo, bs_tdo,
    output shiftir, updateir, shiftdr, clockdr, updatedr,
           bs_en, ir_rst, TDO, tdo_en, state
  );
endinterface : tap_controller_if

// File: rtl/tap_fsm.sv
// -----------------------------------------------------------------------------
// tap_fsm
// IEEE 1149.1 TAP state register and next-state logic.
//   TCK   : clock, all transitions on rising edge
//   TRST  : synchronous active-high reset to TLR (overrides TMS)
//   TMS   : mode select
//   state : registered current state (also the debug view)
// -----------------------------------------------------------------------------
import tap_pkg::*;

module tap_fsm (
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_t state
);

  tap_state_t state_q;
  tap_state_t state_d;

  // State register
  always_ff @(posedge TCK) begin
    if (TRST) state_q <= TLR;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = TMS ? TLR    : RTI;
      RTI:    state_d = TMS ? SEL_DR : RTI;
      SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
      PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
      EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_d = TMS ? SEL_DR : RTI;
      SEL_IR: state_d = TMS ? TLR    : CAP_IR;
      CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
      PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
      EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  assign state = state_q;

endmodule : tap_fsm

// File: rtl/tap_controller.sv
// -----------------------------------------------------------------------------
// tap_controller
// Single-clock JTAG TAP controller: runs the TAP state machine, decodes the
// IR/DR strobes, owns the bypass register and (optionally) the IDCODE
// register, and muxes the selected chain onto TDO.
//
// Parameter:
//   IDCODE : value loaded into the IDCODE register on capture (bit 0 must be 1)
// Ports:
//   TCK  : the only clock
//   TRST : synchronous active-high reset
//   bus  : tap_controller_if.slave (TMS, TDI, inst, ir_tdo, bs_tdo in;
//          shiftir, updateir, shiftdr, clockdr, updatedr, bs_en, ir_rst,
//          TDO, tdo_en, state out)
// Build option:
//   TAP_IDCODE_EN : when defined, the 32-bit IDCODE register exists and
//                   instruction 10 selects it; otherwise instruction 10
//                   behaves as BYPASS.
// -----------------------------------------------------------------------------
import tap_pkg::*;

module tap_controller #(
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic           TCK,
  input  logic           TRST,
  tap_controller_if.slave bus
);

  // An IDCODE with bit 0 clear would be indistinguishable from a bypass
  // register's captured 0, so reject it at elaboration.
  if (IDCODE[0] != 1'b1) begin : g_idcode_lsb_check
    $error("tap_controller: IDCODE bit 0 must be 1");
  end

  tap_state_t   state;
  tap_strobes_t str;

  tap_fsm u_fsm (
    .TCK   (TCK),
    .TRST  (TRST),
    .TMS   (bus.TMS),
    .state (state)
  );

  // ---------------------------------------------------------------------------
  // DR selection, decoded from the live instruction
  // ---------------------------------------------------------------------------
  logic sel_boundary;
  logic sel_bypass;

  assign sel_boundary = inst_is_boundary(bus.inst);

`ifdef TAP_IDCODE_EN
  logic sel_idcode;
  assign sel_idcode = (bus.inst == INST_IDCODE);
  assign sel_bypass = !sel_boundary && !sel_idcode;
`else
  // Without the IDCODE register, instruction 10 falls through to bypass.
  assign sel_bypass = !sel_boundary;
`endif

  // ---------------------------------------------------------------------------
  // Strobe decode (output process). All terms come from the registered state,
  // so the strobes are free of TMS-induced glitches.
  // ---------------------------------------------------------------------------
  always_comb begin
    str          = '0;
    str.ir_rst   = (state == TLR);
    str.shiftir  = (state == CAP_IR) || (state == SH_IR);
    str.updateir = (state == UPD_IR);
    str.shiftdr  = (state == SH_DR);
    str.clockdr  = sel_boundary && ((state == CAP_DR) || (state == SH_DR));
    str.updatedr = sel_boundary && (state == UPD_DR);
    str.bs_en    = (bus.inst == INST_EXTEST);
    str.tdo_en   = (state == SH_IR) || (state == SH_DR);
  end

  assign bus.shiftir  = str.shiftir;
  assign bus.updateir = str.updateir;
  assign bus.shiftdr  = str.shiftdr;
  assign bus.clockdr  = str.clockdr;
  assign bus.updatedr = str.updatedr;
  assign bus.bs_en    = str.bs_en;
  assign bus.ir_rst   = str.ir_rst;
  assign bus.tdo_en   = str.tdo_en;
  assign bus.state    = state;

  // ---------------------------------------------------------------------------
  // Bypass register: one stage between TDI and TDO, captures 0.
  // ---------------------------------------------------------------------------
  logic bypass_q;
  logic bypass_d;

  always_comb begin
    bypass_d = bypass_q;
    if (sel_bypass) begin
      if (state == CAP_DR)     bypass_d = 1'b0;
      else if (state == SH_DR) bypass_d = bus.TDI;
    end
  end

  always_ff @(posedge TCK) begin
    if (TRST) bypass_q <= 1'b0;
    else      bypass_q <= bypass_d;
  end

  // ---------------------------------------------------------------------------
  // IDCODE register: loads the parameter on capture, shifts right with TDI
  // entering at bit 31, bit 0 is the serial output. Only touched while the
  // IDCODE instruction is live so it keeps its value otherwise.
  // ---------------------------------------------------------------------------
`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_q;
  logic [31:0] idcode_d;

  always_comb begin
    idcode_d = idcode_q;
    if (sel_idcode) begin
      if (state == CAP_DR)     idcode_d = IDCODE;
      else if (state == SH_DR) idcode_d = {bus.TDI, idcode_q[31:1]};
    end
  end

  always_ff @(posedge TCK) begin
    if (TRST) idcode_q <= IDCODE;
    else      idcode_q <= idcode_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // TDO mux
  // ---------------------------------------------------------------------------
  logic dr_tdo;
  logic tdo;

  always_comb begin
    dr_tdo = bypass_q;
    if (sel_boundary) dr_tdo = bus.bs_tdo;
`ifdef TAP_IDCODE_EN
    if (sel_idcode)   dr_tdo = idcode_q[0];
`endif
  end

  always_comb begin
    tdo = 1'b0;
    case (state)
      SH_IR:   tdo = bus.ir_tdo;
      SH_DR:   tdo = dr_tdo;
      default: tdo = 1'b0;
    endcase
  end

  assign bus.TDO = tdo;

endmodule : tap_controller
